imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Owns the single shared port of a writable instruction memory (async read, sync write, `WIDTH`-bit words, DEPTH entries).
- Sequences three users of that port: a boot loader stream that fills memory before the CPU runs, the pipeline IF stage during normal execution, and a debug read port that steals single cycles from fetch.
- Generates the CPU hold and fetch-stall signals.

Parameters:
- WIDTH, `WIDTH` (32): instruction/data word width.
- DEPTH, 32: number of instruction words.
- ADDR_W, 5: word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  controller accepts loader word.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  WIDTH  loader word.
- ld_last  in  1  final loader word.
- ld_count  out  ADDR_W+1  words accepted since reset.
- cpu_hold  out  1  holds the pipeline, including PC, in place.
- if_pc  in  WIDTH  byte PC from IF stage.
- if_instr  out  WIDTH  fetched instruction.
- if_stall  out  1  IF must not advance PC this cycle.
- dbg_req  in  1  debug read request (level).
- dbg_addr  in  WIDTH  debug byte address.
- dbg_gnt  out  1  request serviced this cycle.
- dbg_rdata  out  WIDTH  registered debug read data.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory combinational read data.

Behaviour:
- The memory writes mem_wdata at mem_addr on the clk edge when mem_we=1. mem_rdata reflects mem_addr in the same cycle.
- Reset values: state=BOOT, ld_count=0, dbg_rdata=0, dbg_rvalid=0, dbg_gnt=0, mem_we=0. The cpu_hold=1 and ld_ready=1 reset values follow from BOOT.
- Reset is synchronous, so rst asserted in any state returns the controller to BOOT on the next edge. Memory contents are not cleared; a new boot load overwrites them.
- FSM has three states: BOOT, RUN, DBG.
- BOOT:
  - Outputs: ld_ready=1, cpu_hold=1, if_stall=1, if_instr=0 (NOP).
  - Accept occurs when ld_valid=1: same cycle mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data. ld_count increments on the edge.
  - Accepting a word with ld_last=1 moves to RUN on the next edge.
  - ld_count saturates at DEPTH. An accept with ld_count==DEPTH and ld_last=0 still writes the word, and forces RUN.
  - dbg_req is ignored in BOOT.
- RUN:
  - Outputs: ld_ready=0, cpu_hold=0, if_stall=0, mem_we=0.
  - Fetch path: mem_addr=if_pc[ADDR_W+1:2], if_instr=mem_rdata, giving zero-cycle fetch latency.
  - if_pc[1:0] is ignored, and PC bits above ADDR_W+1 are ignored (addresses wrap).
  - ld_valid is ignored; the memory cannot be reloaded without rst.
  - dbg_req=1 moves to DBG on the next edge, unless the previous state was DBG (see fairness rule).
- DBG:
  - Lasts exactly one cycle.
  - Outputs: if_stall=1, if_instr=0, cpu_hold=0, dbg_gnt=1, mem_addr=dbg_addr[ADDR_W+1:2].
  - On the edge: dbg_rdata<=mem_rdata, dbg_rvalid<=1 (high for the following cycle only), next state=RUN.
- Fairness: after a DBG cycle, fetch is guaranteed at least one RUN cycle even if dbg_req stays high. A continuous dbg_req therefore gives alternating RUN/DBG.
- Debug read latency: dbg_gnt cycle, then dbg_rvalid on the next cycle.
- Simultaneous events: rst overrides everything. In BOOT, ld_last with ld_count saturated transitions only once.

Optional Feature:
- Macro: IMEM_BOUND_CHK_EN.
- When defined, adds output if_fault (1 bit).
  - In RUN, if_fault=1 when if_pc[WIDTH-1:ADDR_W+2]!=0 or if_pc[1:0]!=0.
  - In that case if_instr is forced to 0 (NOP) and the memory read is still performed.
  - if_fault is 0 in BOOT and DBG and after reset.
- When undefined: no if_fault port, and addresses wrap silently as above.

Decomposition:
- Shared defines file holds `WIDTH`, the IMEM depth/address-width constants, and the NOP encoding (32'h00000000).
- FSM state encoding (BOOT=2'd0, RUN=2'd1, DBG=2'd2) goes in the shared package so the hazard unit can observe it.
- One natural sub-module: imem_port_mux, a combinational select of mem_addr/mem_we/mem_wdata from state. The FSM, counter and debug register stay in imem_ctrl.

Test Plan:
- Reset, then load 4 words (addr 0..3, data 32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000) with ld_last on word 3.
  - Expect ld_count=4, transition to RUN the cycle after word 3, cpu_hold falls, and if_pc=8 returns 32'h01095020.
- Load with ld_valid gapped (1,0,1,0…) -> only cycles with valid write; ld_count tracks accepts exactly.
- In RUN, pulse dbg_req one cycle with dbg_addr=12.
  - Expect dbg_gnt and if_stall high for 1 cycle, if_instr=0 in that cycle.
  - Expect dbg_rvalid the next cycle with dbg_rdata=32'hAC0A0000.
- Hold dbg_req high for 6 cycles -> state alternates DBG/RUN; if_stall pattern 1,0,1,0,1,0.
- Load 32 words with no ld_last -> forced RUN after word 32; ld_count=32.
- Assert rst during RUN and during DBG -> BOOT next edge, cpu_hold=1, dbg_rvalid=0, ld_count=0.
- With IMEM_BOUND_CHK_EN defined:
  - if_pc=32'h00000080 -> if_fault=1, if_instr=0.
  - if_pc=32'h00000006 -> if_fault=1.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Controller state encoding, shared so the hazard unit can observe the port owner.
`include "imem_defines.svh"

package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        DBG  = 2'd2
    } imem_state_t;

    localparam logic [`WIDTH-1:0] NOP = `IMEM_NOP;

endpackage

// File: rtl/imem_defines.svh
// Shared IMEM constants: word width, depth, address width and the NOP encoding.
`ifndef IMEM_DEFINES_SVH
`define IMEM_DEFINES_SVH

`define WIDTH        32
`define IMEM_DEPTH   32
`define IMEM_ADDR_W  5
`define IMEM_NOP     32'h00000000

`endif

// File: rtl/imem_port_mux.sv
// Selects which user drives the shared IMEM port: loader in BOOT, IF in RUN, debug in DBG.
module imem_port_mux
    import imem_ctrl_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int ADDR_W = `IMEM_ADDR_W
) (
    input  imem_state_t       state,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [ADDR_W-1:0] dbg_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata
);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = fetch_addr;
        mem_wdata = '0;
        case (state)
            BOOT: begin
                mem_we    = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
            end
            DBG:     mem_addr = dbg_word;
            default: mem_addr = fetch_addr;
        endcase
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory port controller: boot load, fetch, and cycle-stealing debug reads.
// Optional IMEM_BOUND_CHK_EN adds if_fault for out-of-range or misaligned fetch PCs.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int DEPTH  = `IMEM_DEPTH,
    parameter int ADDR_W = `IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              ld_last,
    output logic [ADDR_W:0]   ld_count,
    output logic              cpu_hold,
    input  logic [WIDTH-1:0]  if_pc,
    output logic [WIDTH-1:0]  if_instr,
    output logic              if_stall,
`ifdef IMEM_BOUND_CHK_EN
    output logic              if_fault,
`endif
    input  logic              dbg_req,
    input  logic [WIDTH-1:0]  dbg_addr,
    output logic              dbg_gnt,
    output logic [WIDTH-1:0]  dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    imem_state_t state, state_nxt;
    logic        fault;
    logic        ld_done;

    // Bits the word-addressed port never looks at; the wrap is intentional.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_pc[WIDTH-1:ADDR_W+2], if_pc[1:0],
                                dbg_addr[WIDTH-1:ADDR_W+2], dbg_addr[1:0]};

`ifdef IMEM_BOUND_CHK_EN
    assign fault    = (state == RUN) &&
                      ((|if_pc[WIDTH-1:ADDR_W+2]) || (|if_pc[1:0]));
    assign if_fault = fault;
`else
    assign fault    = 1'b0;
`endif

    // Filling the last slot ends the boot even without ld_last.
    assign ld_done = ld_last || (ld_count == LAST_CNT) || (ld_count == FULL_CNT);

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    if (ld_valid && ld_done) state_nxt = RUN;
            RUN:     if (dbg_req) state_nxt = DBG;
            // Unconditional return guarantees fetch a RUN cycle between debug reads.
            DBG:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    assign ld_ready = (state == BOOT);
    assign cpu_hold = (state == BOOT);
    assign if_stall = (state != RUN);
    assign dbg_gnt  = (state == DBG);
    assign if_instr = (state == RUN && !fault) ? mem_rdata : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            ld_count   <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            dbg_rvalid <= (state == DBG);
            if (state == DBG)
                dbg_rdata <= mem_rdata;
            if (state == BOOT && ld_valid && ld_count != FULL_CNT)
                ld_count <= ld_count + 1'b1;
        end
    end

    imem_port_mux #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_mux (
        .state      (state),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .fetch_addr (if_pc[ADDR_W+1:2]),
        .dbg_word   (dbg_addr[ADDR_W+1:2]),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed self-checking bench for imem_ctrl with a behavioural async-read memory.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [5:0]  ld_count;
    logic        cpu_hold;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_stall;
`ifdef IMEM_BOUND_CHK_EN
    logic        if_fault;
`endif
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [32];
    logic [31:0] prog [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    imem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_count   (ld_count),
        .cpu_hold   (cpu_hold),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_stall   (if_stall),
`ifdef IMEM_BOUND_CHK_EN
        .if_fault   (if_fault),
`endif
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || ld_ready !== 1'b1 || if_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_boot_outputs: hold=%b ready=%b stall=%b expected 1 1 1", cpu_hold, ld_ready, if_stall);
        end
        checks++;
        if (ld_count !== 6'd0 || dbg_rvalid !== 1'b0 || dbg_gnt !== 1'b0 || mem_we !== 1'b0 ||
            dbg_rdata !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: cnt=%0d rvalid=%b gnt=%b we=%b rdata=%h instr=%h expected 0", ld_count, dbg_rvalid, dbg_gnt, mem_we, dbg_rdata, if_instr);
        end
`ifdef IMEM_BOUND_CHK_EN
        checks++;
        if (if_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault: got %b expected 0", if_fault);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_boot_load();
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 5'(i);
            ld_data  = prog[i];
            ld_last  = (i == 3);
            #1;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 5'(i) || mem_wdata !== prog[i] ||
                ld_count !== 6'(i) || cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL boot_write[%0d]: we=%b addr=%0d data=%h cnt=%0d hold=%b expected 1 %0d %h %0d 1",
                         i, mem_we, mem_addr, mem_wdata, ld_count, cpu_hold, i, prog[i], i);
            end
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if_pc    = 32'd8;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || if_stall !== 1'b0 || ld_count !== 6'd4) begin
            errors++;
            $display("FAIL boot_to_run: hold=%b ready=%b stall=%b cnt=%0d expected 0 0 0 4", cpu_hold, ld_ready, if_stall, ld_count);
        end
        checks++;
        if (if_instr !== 32'h01095020) begin
            errors++;
            $display("FAIL fetch_pc8: got %h expected 01095020", if_instr);
        end
    endtask

    task automatic test_debug_single();
        dbg_req  = 1'b1;
        dbg_addr = 32'd12;
        if_pc    = 32'd0;
        #1;
        checks++;
        if (dbg_gnt !== 1'b0 || if_instr !== 32'h20080005) begin
            errors++;
            $display("FAIL dbg_req_cycle: gnt=%b instr=%h expected 0 20080005", dbg_gnt, if_instr);
        end
        step();
        dbg_req = 1'b0;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1 || if_stall !== 1'b1 || if_instr !== 32'h0 || mem_addr !== 5'd3 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL dbg_gnt_cycle: gnt=%b stall=%b instr=%h addr=%0d hold=%b expected 1 1 0 3 0",
                     dbg_gnt, if_stall, if_instr, mem_addr, cpu_hold);
        end
        step();
        checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hAC0A0000 || dbg_gnt !== 1'b0 || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL dbg_rvalid_cycle: rvalid=%b rdata=%h gnt=%b stall=%b expected 1 ac0a0000 0 0",
                     dbg_rvalid, dbg_rdata, dbg_gnt, if_stall);
        end
        step();
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dbg_rvalid_pulse: got %b expected 0", dbg_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        dbg_req  = 1'b1;
        dbg_addr = 32'd8;
        step();
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (if_stall !== ((k % 2) == 0) || dbg_gnt !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL dbg_alternate[%0d]: stall=%b gnt=%b expected %b", k, if_stall, dbg_gnt, (k % 2) == 0);
            end
            if (k == 5) dbg_req = 1'b0;
            step();
        end
        checks++;
        if (dbg_rdata !== 32'h01095020 || dbg_gnt !== 1'b0 || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL dbg_stream_end: rdata=%h gnt=%b stall=%b expected 01095020 0 0", dbg_rdata, dbg_gnt, if_stall);
        end
    endtask

    task automatic test_gapped_load();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ld_valid = ((k % 2) == 0);
            ld_addr  = ((k % 2) == 0) ? 5'(4 + k / 2) : 5'd10;
            ld_data  = 32'hC0DE0000 + 32'(k / 2) + (((k % 2) == 0) ? 32'h0 : 32'hBAD0);
            ld_last  = (k == 4);
            #1;
            checks++;
            if (mem_we !== ((k % 2) == 0) || ld_count !== 6'((k + 1) / 2)) begin
                errors++;
                $display("FAIL gapped_load[%0d]: we=%b cnt=%0d expected %b %0d", k, mem_we, ld_count, (k % 2) == 0, (k + 1) / 2);
            end
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if_pc    = 32'd20;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || ld_count !== 6'd3 || if_instr !== 32'hC0DE0001) begin
            errors++;
            $display("FAIL gapped_run: hold=%b cnt=%0d instr=%h expected 0 3 c0de0001", cpu_hold, ld_count, if_instr);
        end
        if_pc = 32'd40;
        #1;
        checks++;
        if (if_instr !== 32'h0) begin
            errors++;
            $display("FAIL gapped_no_write: got %h expected 00000000", if_instr);
        end
        if_pc = 32'd8;
        #1;
        checks++;
        if (if_instr !== 32'h01095020) begin
            errors++;
            $display("FAIL reload_retains: got %h expected 01095020", if_instr);
        end
    endtask

    task automatic test_full_load();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 5'(i);
            ld_data  = 32'h10000000 + 32'(i);
            ld_last  = 1'b0;
            #1;
            checks++;
            if (ld_ready !== 1'b1 || ld_count !== 6'(i) || mem_we !== 1'b1) begin
                errors++;
                $display("FAIL full_load[%0d]: ready=%b cnt=%0d we=%b expected 1 %0d 1", i, ld_ready, ld_count, mem_we, i);
            end
            step();
        end
        ld_addr = 5'd0;
        ld_data = 32'hFFFFFFFF;
        if_pc   = 32'd124;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || ld_count !== 6'd32 || mem_we !== 1'b0 || ld_ready !== 1'b0 ||
            if_instr !== 32'h1000001F) begin
            errors++;
            $display("FAIL forced_run: hold=%b cnt=%0d we=%b ready=%b instr=%h expected 0 32 0 0 1000001f",
                     cpu_hold, ld_count, mem_we, ld_ready, if_instr);
        end
        step();
        ld_valid = 1'b0;
        if_pc    = 32'd0;
        #1;
        checks++;
        if (if_instr !== 32'h10000000) begin
            errors++;
            $display("FAIL run_ignores_loader: got %h expected 10000000", if_instr);
        end
        if_pc = 32'h00000080;
        #1;
`ifdef IMEM_BOUND_CHK_EN
        checks++;
        if (if_fault !== 1'b1 || if_instr !== 32'h0 || mem_addr !== 5'd0) begin
            errors++;
            $display("FAIL fault_high_pc: fault=%b instr=%h addr=%0d expected 1 0 0", if_fault, if_instr, mem_addr);
        end
        if_pc = 32'h00000006;
        #1;
        checks++;
        if (if_fault !== 1'b1 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL fault_misaligned: fault=%b instr=%h expected 1 0", if_fault, if_instr);
        end
        if_pc = 32'h00000004;
        #1;
        checks++;
        if (if_fault !== 1'b0 || if_instr !== 32'h10000001) begin
            errors++;
            $display("FAIL fault_clear: fault=%b instr=%h expected 0 10000001", if_fault, if_instr);
        end
`else
        checks++;
        if (if_instr !== 32'h10000000) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected 10000000", if_instr);
        end
        if_pc = 32'h00000007;
        #1;
        checks++;
        if (if_instr !== 32'h10000001) begin
            errors++;
            $display("FAIL pc_low_bits: got %h expected 10000001", if_instr);
        end
`endif
    endtask

    task automatic test_reset_run_dbg();
        if_pc = 32'd0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || ld_ready !== 1'b1 || ld_count !== 6'd0 || dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run: hold=%b ready=%b cnt=%0d rvalid=%b expected 1 1 0 0", cpu_hold, ld_ready, ld_count, dbg_rvalid);
        end
        ld_valid = 1'b1;
        ld_addr  = 5'd0;
        ld_data  = 32'h12345678;
        ld_last  = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = 32'd0;
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || if_instr !== 32'h12345678 || ld_count !== 6'd1) begin
            errors++;
            $display("FAIL reload_run: hold=%b instr=%h cnt=%0d expected 0 12345678 1", cpu_hold, if_instr, ld_count);
        end
        step();
        checks++;
        if (dbg_gnt !== 1'b1) begin
            errors++;
            $display("FAIL dbg_before_reset: gnt=%b expected 1", dbg_gnt);
        end
        rst     = 1'b1;
        dbg_req = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0 || ld_count !== 6'd0 || dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_dbg: hold=%b rvalid=%b rdata=%h cnt=%0d gnt=%b expected 1 0 0 0 0",
                     cpu_hold, dbg_rvalid, dbg_rdata, ld_count, dbg_gnt);
        end
    endtask

    initial begin
        prog[0] = 32'h20080005;
        prog[1] = 32'h20090003;
        prog[2] = 32'h01095020;
        prog[3] = 32'hAC0A0000;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        ld_last  = 1'b0;
        if_pc    = '0;
        dbg_req  = 1'b0;
        dbg_addr = '0;

        test_reset();
        test_boot_load();
        test_debug_single();
        test_back_to_back();
        test_gapped_load();
        test_full_load();
        test_reset_run_dbg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
